fft_frame_padder: RTL and testbench

Input framing stage for the fast Fourier correlation datapath. Takes a variable-length burst of N complex samples from an AXI-Stream source and emits exactly NFFT samples downstream: the N input samples followed by NFFT−N zeros, with tlast on the final sample. One instance sits in front of each FFT input (func_1 and func_2 paths). It provides the zero-padding the correlator needs for linear, not circular, correlation.

---
 rtl/fft_frame_padder_if.sv | 12 +
 rtl/fft_frame_padder.sv | 141 ++++++++++++++
 tb/tb_fft_frame_padder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_padder_if.sv
// AXI-Stream style sample channel shared by the padder's input and output sides.
interface fft_frame_padder_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/fft_frame_padder.sv
// Frames a variable-length burst of N samples into exactly NFFT output beats:
// the N input samples followed by zeros, with tlast on beat NFFT-1.
module fft_frame_padder #(
  parameter int unsigned NFFT   = 256,
  parameter int unsigned DATA_W = 32
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                start,
  input  logic [12:0]         N,
  output logic                idle,
  output logic                len_error,
  fft_frame_padder_if.slave   s,
  fft_frame_padder_if.master  m
);

  localparam int unsigned    CW       = $clog2(NFFT) + 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(NFFT - 1);
  localparam logic [CW-1:0]  NFFT_C   = CW'(NFFT);

  typedef enum logic [1:0] {IDLE, PASS, PAD} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     n_q, n_d;
  logic [CW-1:0]     in_cnt_q, in_cnt_d;
  logic [CW-1:0]     out_cnt_q, out_cnt_d;
  logic [CW-1:0]     ld_cnt_q, ld_cnt_d;
  logic              len_err_q, len_err_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              s_ready;
  logic              out_hs;
  logic              reg_free;

  // State and datapath registers; reset drops any partial frame.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      n_q       <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      ld_cnt_q  <= '0;
      len_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
      len_err_q <= len_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
    end
  end

  // Next-state, output-register loading and handshake control.
  // ld_cnt tracks beats loaded into the output register (pass + pad), so tlast
  // is tagged at load time; out_cnt tracks beats actually consumed and decides
  // when the frame is complete.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    ld_cnt_d  = ld_cnt_q;
    len_err_d = len_err_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    s_ready   = 1'b0;

    out_hs   = valid_q && m.tready;
    reg_free = !valid_q || m.tready;

    if (out_hs) begin
      out_cnt_d = out_cnt_q + CW'(1);
      valid_d   = 1'b0;
      last_d    = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (N != 13'd0 && N <= 13'(NFFT)) begin
            n_d       = N[CW-1:0];
            len_err_d = 1'b0;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            ld_cnt_d  = '0;
            state_d   = PASS;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      PASS: begin
        s_ready = reg_free && (in_cnt_q < n_q);
        if (s.tvalid && s_ready) begin
          data_d   = s.tdata;
          valid_d  = 1'b1;
          last_d   = (ld_cnt_q == LAST_IDX);
          ld_cnt_d = ld_cnt_q + CW'(1);
          in_cnt_d = in_cnt_q + CW'(1);
          if ((in_cnt_q + CW'(1) == n_q) && (n_q < NFFT_C)) begin
            state_d = PAD;
          end
        end
        if (out_hs && out_cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      PAD: begin
        if (reg_free && ld_cnt_q < NFFT_C) begin
          data_d   = '0;
          valid_d  = 1'b1;
          last_d   = (ld_cnt_q == LAST_IDX);
          ld_cnt_d = ld_cnt_q + CW'(1);
        end
        if (out_hs && out_cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign idle      = (state_q == IDLE);
  assign len_error = len_err_q;
  assign s.tready  = s_ready;
  assign m.tdata   = data_q;
  assign m.tvalid  = valid_q;
  assign m.tlast   = last_q;

endmodule

// File: tb/tb_fft_frame_padder.sv
// Directed bench for fft_frame_padder with NFFT=8.
module tb_fft_frame_padder;
  localparam int unsigned NFFT   = 8;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [12:0] n_in;
  logic idle;
  logic len_error;

  fft_frame_padder_if #(.DATA_W(DATA_W)) s_if ();
  fft_frame_padder_if #(.DATA_W(DATA_W)) m_if ();

  fft_frame_padder #(.NFFT(NFFT), .DATA_W(DATA_W)) dut (
    .aclk      (clk),
    .areset    (rst),
    .start     (start),
    .N         (n_in),
    .idle      (idle),
    .len_error (len_error),
    .s         (s_if),
    .m         (m_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] src [16];
  logic [31:0] got_d [$];
  logic        got_l [$];
  int unsigned acc;
  int unsigned stall_err;
  int unsigned pad_err;
  bit          tmo;
  logic        idle_after;
  logic        idle_at_start;
  logic        rdy_at_start;

  // Starts one frame from the current (post-edge) point and collects output beats.
  task automatic run_frame(input logic [12:0] n, input int unsigned vpct, input int unsigned rpct);
    logic        held;
    logic [31:0] hd;
    logic        hl;
    bit          done;
    got_d.delete();
    got_l.delete();
    acc = 0; stall_err = 0; pad_err = 0; tmo = 1'b1; idle_after = 1'b0;
    held = 1'b0; hd = '0; hl = 1'b0;
    start = 1'b1; n_in = n; s_if.tvalid = 1'b0; m_if.tready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    idle_at_start = idle;
    rdy_at_start  = s_if.tready;
    for (int c = 0; c < 400; c++) begin
      s_if.tvalid = ($urandom_range(99) < vpct);
      s_if.tdata  = src[acc];
      m_if.tready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (held && (m_if.tvalid !== 1'b1 || m_if.tdata !== hd || m_if.tlast !== hl)) stall_err++;
      held = m_if.tvalid && !m_if.tready;
      hd = m_if.tdata;
      hl = m_if.tlast;
      if (s_if.tready && acc >= n) pad_err++;
      done = m_if.tvalid && m_if.tready && m_if.tlast;
      if (m_if.tvalid && m_if.tready) begin
        got_d.push_back(m_if.tdata);
        got_l.push_back(m_if.tlast);
      end
      if (s_if.tvalid && s_if.tready) acc++;
      @(posedge clk); #1;
      if (done) begin
        idle_after = idle;
        tmo = 1'b0;
        break;
      end
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; n_in = '0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b0;
    #12;
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
    n_cmp++; if (len_error !== 1'b0) begin n_bad++; $display("FAIL reset_len_error got=%b exp=0", len_error); end
    n_cmp++; if (s_if.tready !== 1'b0) begin n_bad++; $display("FAIL reset_s_tready got=%b exp=0", s_if.tready); end
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_m_tvalid got=%b exp=0", m_if.tvalid); end
    n_cmp++; if (m_if.tlast !== 1'b0) begin n_bad++; $display("FAIL reset_m_tlast got=%b exp=0", m_if.tlast); end
    n_cmp++; if (m_if.tdata !== 32'h0) begin n_bad++; $display("FAIL reset_m_tdata got=%h exp=0", m_if.tdata); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] exp_d;
    for (int i = 0; i < 16; i++) src[i] = 32'h0;
    src[0] = 32'h11; src[1] = 32'h22; src[2] = 32'h33; src[3] = 32'h44;
    run_frame(13'd3, 100, 100);
    n_cmp++; if (idle_at_start !== 1'b0) begin n_bad++; $display("FAIL basic_idle_after_start got=%b exp=0", idle_at_start); end
    n_cmp++; if (rdy_at_start !== 1'b1) begin n_bad++; $display("FAIL basic_tready_after_start got=%b exp=1", rdy_at_start); end
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL basic_timeout got=%b exp=0", tmo); end
    n_cmp++; if (got_d.size() != 8) begin n_bad++; $display("FAIL basic_beats got=%0d exp=8", got_d.size()); end
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      exp_d = (i < 3) ? src[i] : 32'h0;
      n_cmp++; if (got_d[i] !== exp_d) begin n_bad++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, got_d[i], exp_d); end
      n_cmp++; if (got_l[i] !== (i == 7)) begin n_bad++; $display("FAIL basic_tlast[%0d] got=%b exp=%b", i, got_l[i], (i == 7)); end
    end
    n_cmp++; if (idle_after !== 1'b1) begin n_bad++; $display("FAIL basic_idle_after_last got=%b exp=1", idle_after); end
    n_cmp++; if (acc != 3) begin n_bad++; $display("FAIL basic_accepted got=%0d exp=3", acc); end
    n_cmp++; if (pad_err != 0) begin n_bad++; $display("FAIL basic_tready_in_pad got=%0d exp=0", pad_err); end
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < 16; i++) src[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    run_frame(13'd8, 100, 100);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL full_timeout got=%b exp=0", tmo); end
    n_cmp++; if (got_d.size() != 8) begin n_bad++; $display("FAIL full_beats got=%0d exp=8", got_d.size()); end
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== src[i]) begin n_bad++; $display("FAIL full_data[%0d] got=%h exp=%h", i, got_d[i], src[i]); end
      n_cmp++; if (got_l[i] !== (i == 7)) begin n_bad++; $display("FAIL full_tlast[%0d] got=%b exp=%b", i, got_l[i], (i == 7)); end
    end
    n_cmp++; if (acc != 8) begin n_bad++; $display("FAIL full_accepted got=%0d exp=8", acc); end
    n_cmp++; if (pad_err != 0) begin n_bad++; $display("FAIL full_extra_accept got=%0d exp=0", pad_err); end
    n_cmp++; if (idle_after !== 1'b1) begin n_bad++; $display("FAIL full_idle_after_last got=%b exp=1", idle_after); end
  endtask

  task automatic test_len_error();
    logic [12:0] bad_n [2];
    bad_n[0] = 13'd0; bad_n[1] = 13'd9;
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; n_in = bad_n[k];
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++; if (len_error !== 1'b1) begin n_bad++; $display("FAIL lenerr_set[N=%0d] got=%b exp=1", bad_n[k], len_error); end
      n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL lenerr_idle[N=%0d] got=%b exp=1", bad_n[k], idle); end
      @(posedge clk); #1;
      n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL lenerr_no_output[N=%0d] got=%b exp=0", bad_n[k], m_if.tvalid); end
    end
    for (int i = 0; i < 16; i++) src[i] = 32'hC0DE_0000 + 32'(i);
    run_frame(13'd4, 100, 100);
    n_cmp++; if (len_error !== 1'b0) begin n_bad++; $display("FAIL lenerr_cleared got=%b exp=0", len_error); end
    n_cmp++; if (got_d.size() != 8) begin n_bad++; $display("FAIL lenerr_recover_beats got=%0d exp=8", got_d.size()); end
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== ((i < 4) ? src[i] : 32'h0)) begin n_bad++; $display("FAIL lenerr_recover_data[%0d] got=%h", i, got_d[i]); end
    end
  endtask

  task automatic test_stalls();
    logic [31:0] exp_d;
    for (int i = 0; i < 16; i++) src[i] = 32'hABCD_0000 + 32'(i) * 32'h11;
    run_frame(13'd5, 60, 50);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL stall_timeout got=%b exp=0", tmo); end
    n_cmp++; if (got_d.size() != 8) begin n_bad++; $display("FAIL stall_beats got=%0d exp=8", got_d.size()); end
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      exp_d = (i < 5) ? src[i] : 32'h0;
      n_cmp++; if (got_d[i] !== exp_d) begin n_bad++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, got_d[i], exp_d); end
      n_cmp++; if (got_l[i] !== (i == 7)) begin n_bad++; $display("FAIL stall_tlast[%0d] got=%b exp=%b", i, got_l[i], (i == 7)); end
    end
    n_cmp++; if (stall_err != 0) begin n_bad++; $display("FAIL stall_hold got=%0d exp=0", stall_err); end
    n_cmp++; if (pad_err != 0) begin n_bad++; $display("FAIL stall_tready_in_pad got=%0d exp=0", pad_err); end
    n_cmp++; if (acc != 5) begin n_bad++; $display("FAIL stall_accepted got=%0d exp=5", acc); end
  endtask

  task automatic test_reset_mid_frame();
    start = 1'b1; n_in = 13'd3;
    s_if.tvalid = 1'b1; s_if.tdata = 32'h7777_7777; m_if.tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    n_cmp++; if (m_if.tvalid !== 1'b1) begin n_bad++; $display("FAIL midrst_in_pad_valid got=%b exp=1", m_if.tvalid); end
    m_if.tready = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL midrst_m_tvalid got=%b exp=0", m_if.tvalid); end
    n_cmp++; if (m_if.tlast !== 1'b0) begin n_bad++; $display("FAIL midrst_m_tlast got=%b exp=0", m_if.tlast); end
    n_cmp++; if (m_if.tdata !== 32'h0) begin n_bad++; $display("FAIL midrst_m_tdata got=%h exp=0", m_if.tdata); end
    n_cmp++; if (s_if.tready !== 1'b0) begin n_bad++; $display("FAIL midrst_s_tready got=%b exp=0", s_if.tready); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL midrst_idle got=%b exp=1", idle); end
    s_if.tvalid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) src[i] = 32'h0;
    src[0] = 32'hDEAD_BEEF; src[1] = 32'h0BAD_F00D;
    run_frame(13'd2, 100, 100);
    n_cmp++; if (got_d.size() != 8) begin n_bad++; $display("FAIL midrst_next_beats got=%0d exp=8", got_d.size()); end
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== ((i < 2) ? src[i] : 32'h0)) begin n_bad++; $display("FAIL midrst_next_data[%0d] got=%h", i, got_d[i]); end
      n_cmp++; if (got_l[i] !== (i == 7)) begin n_bad++; $display("FAIL midrst_next_tlast[%0d] got=%b exp=%b", i, got_l[i], (i == 7)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] f2 [7];
    for (int i = 0; i < 16; i++) src[i] = 32'h0;
    src[0] = 32'h0000_00A1; src[1] = 32'hFFFF_FFFF;
    run_frame(13'd1, 100, 100);
    n_cmp++; if (got_d.size() != 8) begin n_bad++; $display("FAIL b2b_f1_beats got=%0d exp=8", got_d.size()); end
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== ((i == 0) ? 32'h0000_00A1 : 32'h0)) begin n_bad++; $display("FAIL b2b_f1_data[%0d] got=%h", i, got_d[i]); end
      n_cmp++; if (got_l[i] !== (i == 7)) begin n_bad++; $display("FAIL b2b_f1_tlast[%0d] got=%b exp=%b", i, got_l[i], (i == 7)); end
    end
    for (int i = 0; i < 7; i++) begin
      f2[i] = 32'h5A5A_0000 + 32'(i + 1);
      src[i] = f2[i];
    end
    src[7] = 32'h9999_9999;
    run_frame(13'd7, 100, 100);
    n_cmp++; if (idle_at_start !== 1'b0) begin n_bad++; $display("FAIL b2b_f2_accepted got_idle=%b exp=0", idle_at_start); end
    n_cmp++; if (got_d.size() != 8) begin n_bad++; $display("FAIL b2b_f2_beats got=%0d exp=8", got_d.size()); end
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== ((i < 7) ? f2[i] : 32'h0)) begin n_bad++; $display("FAIL b2b_f2_data[%0d] got=%h", i, got_d[i]); end
      n_cmp++; if (got_l[i] !== (i == 7)) begin n_bad++; $display("FAIL b2b_f2_tlast[%0d] got=%b exp=%b", i, got_l[i], (i == 7)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_frame();
    test_len_error();
    test_stalls();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
